// File: rtl/mec_8255_pkg.sv
// Shared constants and helpers for the mec_8255 8255-style PPI (mode 0 only).
package mec_8255_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned HALF_W = 4;

  // Register select decode
  localparam logic [ADDR_W-1:0] ADDR_PA   = 2'b00;
  localparam logic [ADDR_W-1:0] ADDR_PB   = 2'b01;
  localparam logic [ADDR_W-1:0] ADDR_PC   = 2'b10;
  localparam logic [ADDR_W-1:0] ADDR_CTRL = 2'b11;

  // Control-word bit positions (direction bits: 1 = input, 0 = output)
  localparam int unsigned CTRL_MODE_SET_BIT = 7;
  localparam int unsigned CTRL_PA_DIR_BIT   = 4;
  localparam int unsigned CTRL_PCU_DIR_BIT  = 3;
  localparam int unsigned CTRL_PB_DIR_BIT   = 1;
  localparam int unsigned CTRL_PCL_DIR_BIT  = 0;

  localparam logic [DATA_W-1:0] CTRL_RESET = 8'h9B;

  // Port C bit set/reset: cmd[3:1] selects the bit, cmd[0] is its new value.
  function automatic logic [DATA_W-1:0] bsr_apply(input logic [DATA_W-1:0] cur,
                                                  input logic [DATA_W-1:0] cmd);
    logic [DATA_W-1:0] res;
    res = cur;
    res[cmd[3:1]] = cmd[0];
    return res;
  endfunction

endpackage

// File: rtl/mec_8255_port.sv
// One PPI port group: output latch, direction bit, input sample register and
// tristate pin driver.
//   clk, reset : clock and synchronous active-high reset
//   wr_en      : load wr_data into the output latch
//   dir_en     : load dir_val into the direction bit (1 = input)
//   pins       : external tristate pins
//   latch      : current output latch value
//   is_input   : current direction
//   sample     : pins registered every clock
module mec_8255_port #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         dir_en,
  input  logic         dir_val,
  inout  wire  [W-1:0] pins,
  output logic [W-1:0] latch,
  output logic         is_input,
  output logic [W-1:0] sample
);

  // Latch, direction and pin sample registers
  always_ff @(posedge clk) begin
    if (reset) begin
      latch    <= '0;
      is_input <= 1'b1;
      sample   <= '0;
    end else begin
      if (wr_en) latch <= wr_data;
      if (dir_en) is_input <= dir_val;
      sample <= pins;
    end
  end

  // Output groups drive their latch continuously; input groups float
  assign pins = is_input ? {W{1'bz}} : latch;

endmodule

// File: rtl/mec_8255.sv
// Clocked 8255 PPI, mode 0: three 8-bit ports on an 8085-style bus.
//   Clk, Reset       : clock and synchronous active-high reset
//   d                : CPU data bus, driven only during a valid read
//   A                : register select (PA, PB, PC, control)
//   Cs_n, Wr_n, Rd_n : active-low chip select, write and read strobes
//   Pa, Pb, Pc       : port pins; Pc upper/lower halves directed separately
module mec_8255
  import mec_8255_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  inout  wire  [DATA_W-1:0] d,
  input  logic [ADDR_W-1:0] A,
  input  logic              Cs_n,
  input  logic              Wr_n,
  input  logic              Rd_n,
  inout  wire  [DATA_W-1:0] Pa,
  inout  wire  [DATA_W-1:0] Pb,
  inout  wire  [DATA_W-1:0] Pc
);

  logic              wr_act_c;
  logic              rd_act_c;
  logic              wr_q;
  logic              commit_c;
  logic              mode_set_c;
  logic              bsr_c;
  logic [DATA_W-1:0] ctrl;
  logic [DATA_W-1:0] pc_bsr_c;
  logic [DATA_W-1:0] rd_data_c;

  logic [DATA_W-1:0] pa_latch, pa_sample, pb_latch, pb_sample;
  logic [HALF_W-1:0] pcu_latch, pcu_sample, pcl_latch, pcl_sample;
  logic              pa_is_in, pb_is_in, pcu_is_in, pcl_is_in;

  logic              pa_wr_c, pb_wr_c, pcu_wr_c, pcl_wr_c;
  logic [DATA_W-1:0] pa_data_c, pb_data_c;
  logic [HALF_W-1:0] pcu_data_c, pcl_data_c;

  // Bus decode; all three strobes low counts as neither access
  assign wr_act_c = !Cs_n && !Wr_n && Rd_n;
  assign rd_act_c = !Cs_n && !Rd_n && Wr_n;

  // Strobe history is tracked through reset as well, so a strobe held across
  // reset release is not seen as a fresh edge.
  always_ff @(posedge Clk) begin
    wr_q <= wr_act_c;
  end

  assign commit_c   = wr_act_c && !wr_q;
  assign mode_set_c = commit_c && (A == ADDR_CTRL) && d[CTRL_MODE_SET_BIT];
  assign bsr_c      = commit_c && (A == ADDR_CTRL) && !d[CTRL_MODE_SET_BIT];
  assign pc_bsr_c   = bsr_apply({pcu_latch, pcl_latch}, d);

  // Control register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ctrl <= CTRL_RESET;
    end else if (mode_set_c) begin
      ctrl <= d;
    end
  end

  // Latch load selection: mode set clears, BSR patches PC, data writes load
  always_comb begin
    pa_wr_c    = mode_set_c || (commit_c && (A == ADDR_PA));
    pb_wr_c    = mode_set_c || (commit_c && (A == ADDR_PB));
    pcu_wr_c   = mode_set_c || bsr_c || (commit_c && (A == ADDR_PC));
    pcl_wr_c   = pcu_wr_c;
    pa_data_c  = d;
    pb_data_c  = d;
    pcu_data_c = d[7:4];
    pcl_data_c = d[3:0];
    if (mode_set_c) begin
      pa_data_c  = '0;
      pb_data_c  = '0;
      pcu_data_c = '0;
      pcl_data_c = '0;
    end else if (bsr_c) begin
      pcu_data_c = pc_bsr_c[7:4];
      pcl_data_c = pc_bsr_c[3:0];
    end
  end

  mec_8255_port #(.W(DATA_W)) u_pa (
    .clk(Clk), .reset(Reset), .wr_en(pa_wr_c), .wr_data(pa_data_c),
    .dir_en(mode_set_c), .dir_val(d[CTRL_PA_DIR_BIT]), .pins(Pa),
    .latch(pa_latch), .is_input(pa_is_in), .sample(pa_sample)
  );

  mec_8255_port #(.W(DATA_W)) u_pb (
    .clk(Clk), .reset(Reset), .wr_en(pb_wr_c), .wr_data(pb_data_c),
    .dir_en(mode_set_c), .dir_val(d[CTRL_PB_DIR_BIT]), .pins(Pb),
    .latch(pb_latch), .is_input(pb_is_in), .sample(pb_sample)
  );

  mec_8255_port #(.W(HALF_W)) u_pcu (
    .clk(Clk), .reset(Reset), .wr_en(pcu_wr_c), .wr_data(pcu_data_c),
    .dir_en(mode_set_c), .dir_val(d[CTRL_PCU_DIR_BIT]), .pins(Pc[7:4]),
    .latch(pcu_latch), .is_input(pcu_is_in), .sample(pcu_sample)
  );

  mec_8255_port #(.W(HALF_W)) u_pcl (
    .clk(Clk), .reset(Reset), .wr_en(pcl_wr_c), .wr_data(pcl_data_c),
    .dir_en(mode_set_c), .dir_val(d[CTRL_PCL_DIR_BIT]), .pins(Pc[3:0]),
    .latch(pcl_latch), .is_input(pcl_is_in), .sample(pcl_sample)
  );

  // Read mux: input groups return sampled pins, output groups their latch
  always_comb begin
    rd_data_c = ctrl;
    case (A)
      ADDR_PA: rd_data_c = pa_is_in ? pa_sample : pa_latch;
      ADDR_PB: rd_data_c = pb_is_in ? pb_sample : pb_latch;
      ADDR_PC: rd_data_c = {pcu_is_in ? pcu_sample : pcu_latch,
                            pcl_is_in ? pcl_sample : pcl_latch};
      default: rd_data_c = ctrl;
    endcase
  end

  assign d = rd_act_c ? rd_data_c : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mec_8255.sv
// Self-checking bench for mec_8255. Bus and pin nets carry pull-ups (a board
// with pull resistors), so an undriven net reads 8'hFF and any unwanted DUT
// drive shows up as a wrong value.
module tb_mec_8255;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] A;
  logic       Cs_n, Wr_n, Rd_n;

  tri1 [7:0] d, Pa, Pb, Pc;

  logic       d_en, pa_en, pb_en, pcu_en, pcl_en;
  logic [7:0] d_drv, pa_drv, pb_drv, pc_drv;

  assign d       = d_en   ? d_drv       : 8'hzz;
  assign Pa      = pa_en  ? pa_drv      : 8'hzz;
  assign Pb      = pb_en  ? pb_drv      : 8'hzz;
  assign Pc[7:4] = pcu_en ? pc_drv[7:4] : 4'hz;
  assign Pc[3:0] = pcl_en ? pc_drv[3:0] : 4'hz;

  always #5 Clk = ~Clk;

  mec_8255 dut (
    .Clk(Clk), .Reset(Reset), .d(d), .A(A),
    .Cs_n(Cs_n), .Wr_n(Wr_n), .Rd_n(Rd_n),
    .Pa(Pa), .Pb(Pb), .Pc(Pc)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: control word plus one byte of output latch per port
  logic [7:0] m_ctrl;
  logic [7:0] m_lat [3];

  function automatic void model_reset();
    m_ctrl = 8'h9B;
    for (int i = 0; i < 3; i++) m_lat[i] = 8'h00;
  endfunction

  function automatic void model_write(input logic [1:0] a, input logic [7:0] v);
    if (a == 2'd3) begin
      if (v[7]) begin
        m_ctrl = v;
        for (int i = 0; i < 3; i++) m_lat[i] = 8'h00;
      end else begin
        m_lat[2][v[3:1]] = v[0];
      end
    end else begin
      m_lat[a] = v;
    end
  endfunction

  // What a pin group should show: latch when output, external value when input
  function automatic logic [7:0] exp_pins(input int p);
    logic [3:0] hi, lo;
    case (p)
      0: return m_ctrl[4] ? (pa_en ? pa_drv : 8'hFF) : m_lat[0];
      1: return m_ctrl[1] ? (pb_en ? pb_drv : 8'hFF) : m_lat[1];
      default: begin
        hi = m_ctrl[3] ? (pcu_en ? pc_drv[7:4] : 4'hF) : m_lat[2][7:4];
        lo = m_ctrl[0] ? (pcl_en ? pc_drv[3:0] : 4'hF) : m_lat[2][3:0];
        return {hi, lo};
      end
    endcase
  endfunction

  function automatic logic [7:0] exp_read(input logic [1:0] a);
    return (a == 2'd3) ? m_ctrl : exp_pins(int'(a));
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] v);
    @(posedge Clk); #1;
    A = a; d_drv = v; d_en = 1'b1; Cs_n = 1'b0; Wr_n = 1'b0;
    @(posedge Clk); #1;
    Cs_n = 1'b1; Wr_n = 1'b1; d_en = 1'b0;
    model_write(a, v);
  endtask

  task automatic bus_read_check(input logic [1:0] a, input string tag);
    @(posedge Clk); #1;
    A = a; Cs_n = 1'b0; Rd_n = 1'b0;
    @(negedge Clk);
    check(tag, d, exp_read(a));
    @(posedge Clk); #1;
    Cs_n = 1'b1; Rd_n = 1'b1;
  endtask

  task automatic check_pins(input string tag);
    @(negedge Clk);
    check({tag, "_pa"}, Pa, exp_pins(0));
    check({tag, "_pb"}, Pb, exp_pins(1));
    check({tag, "_pc"}, Pc, exp_pins(2));
  endtask

  task automatic release_pins();
    pa_en = 1'b0; pb_en = 1'b0; pcu_en = 1'b0; pcl_en = 1'b0;
  endtask

  // Drive random values on whichever groups the model says are inputs
  task automatic apply_drives();
    pa_drv = 8'($urandom); pb_drv = 8'($urandom); pc_drv = 8'($urandom);
    pa_en  = m_ctrl[4]; pb_en = m_ctrl[1]; pcu_en = m_ctrl[3]; pcl_en = m_ctrl[0];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; A = 2'd0; Cs_n = 1'b1; Wr_n = 1'b1; Rd_n = 1'b1;
    d_en = 1'b0; d_drv = 8'h00; pa_drv = 8'h00; pb_drv = 8'h00; pc_drv = 8'h00;
    release_pins();
    model_reset();
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;

    // Reset state: all groups inputs and floating, ctrl readable
    bus_read_check(2'd0, "rst_rd_pa");
    bus_read_check(2'd1, "rst_rd_pb");
    bus_read_check(2'd2, "rst_rd_pc");
    bus_read_check(2'd3, "rst_rd_ctrl");
    check_pins("rst");

    // PB input, PA and PC outputs
    bus_write(2'd3, 8'h82);
    pb_drv = 8'hA5; pb_en = 1'b1;
    bus_read_check(2'd1, "m82_rd_pb");
    check_pins("m82");

    // PA data write
    bus_write(2'd0, 8'hA5);
    check_pins("pa_wr");
    bus_read_check(2'd0, "pa_wr_rd");

    // Port C bit set/reset
    pb_en = 1'b0;
    bus_write(2'd3, 8'h80);
    bus_write(2'd3, 8'h0F);
    check_pins("bsr_set7");
    bus_write(2'd3, 8'h0C);
    check_pins("bsr_clr6");
    bus_write(2'd3, 8'h0E);
    check_pins("bsr_clr7");

    // PC upper input, lower output
    bus_write(2'd3, 8'h88);
    pc_drv = 8'hC0; pcu_en = 1'b1;
    bus_write(2'd2, 8'h03);
    bus_read_check(2'd2, "pc_split_rd");
    check_pins("pc_split");

    // Long write strobe: one commit only
    @(posedge Clk); #1;
    A = 2'd0; d_drv = 8'h55; d_en = 1'b1; Cs_n = 1'b0; Wr_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      if (i == 0) model_write(2'd0, 8'h55);
      @(negedge Clk);
      check("hold55_pa", Pa, exp_pins(0));
    end
    #1 Cs_n = 1'b1; Wr_n = 1'b1; d_en = 1'b0;

    // Long strobe with data changing after the first edge
    @(posedge Clk); #1;
    A = 2'd0; d_drv = 8'h33; d_en = 1'b1; Cs_n = 1'b0; Wr_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      if (i == 0) model_write(2'd0, 8'h33);
      #1 d_drv = 8'($urandom);
      @(negedge Clk);
      check("hold_var_pa", Pa, exp_pins(0));
    end
    #1 Cs_n = 1'b1; Wr_n = 1'b1; d_en = 1'b0;

    // All three strobes low: no read, no write
    @(posedge Clk); #1;
    A = 2'd0; Cs_n = 1'b0; Rd_n = 1'b0; Wr_n = 1'b0;
    @(negedge Clk);
    check("all_low_d", d, 8'hFF);
    @(posedge Clk);
    @(negedge Clk);
    check("all_low_pa", Pa, exp_pins(0));
    #1 Cs_n = 1'b1; Rd_n = 1'b1; Wr_n = 1'b1;

    // Control strobe held across reset must not commit on release
    release_pins();
    @(posedge Clk); #1;
    Reset = 1'b1; A = 2'd3; d_drv = 8'h80; d_en = 1'b1; Cs_n = 1'b0; Wr_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1 Cs_n = 1'b1; Wr_n = 1'b1; d_en = 1'b0;
    bus_read_check(2'd3, "rst_held_ctrl");
    check_pins("rst_held");

    // Randomized traffic against the model
    apply_drives();
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 4))
        0: bus_write(2'($urandom_range(0, 2)), 8'($urandom));
        1: begin
          release_pins();
          bus_write(2'd3, {1'b1, 7'($urandom)});
          apply_drives();
        end
        2: bus_write(2'd3, {1'b0, 7'($urandom)});
        3: apply_drives();
        default: @(posedge Clk);
      endcase
      bus_read_check(2'($urandom_range(0, 3)), "rnd_rd");
      check_pins("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
